// File: rtl/map_updater.sv
// Occupancy-grid log-odds updater: queues ray-tracer cell hits and read-modify-writes the map RAM.
// Read strobe 2 cycles, write strobe 4 cycles after an idle write; 1 update/3 cycles; hits arriving while full are dropped and flagged.

package ram_pkg;
  // One bit wider than a 64-cell axis so out-of-range coordinates can reach the range check.
  typedef logic [6:0] width_index_t;
  typedef logic [6:0] height_index_t;
endpackage

module map_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign pop_dat = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
endmodule

module map_updater
  import ram_pkg::*;
#(
  parameter int MAP_WIDTH  = 64,
  parameter int MAP_HEIGHT = 64,
  parameter int ADDR_BITS  = 12,
  parameter int CELL_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int OCC_DELTA  = 3,
  parameter int FREE_DELTA = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  width_index_t         x_index,
  input  height_index_t        y_index,
  input  logic                 cell_is_free,
  input  logic                 write_enable,
  input  logic                 clear_overflow,
  output logic [ADDR_BITS-1:0] ram_address,
  output logic                 ram_read_enable,
  input  logic [CELL_BITS-1:0] ram_read_data,
  output logic                 ram_write_enable,
  output logic [CELL_BITS-1:0] ram_write_data,
  output logic                 full,
  output logic                 idle,
  output logic                 overflow
);
  typedef enum logic [1:0] {IDLE, READ, WAIT, WRITE} state_t;

  localparam logic signed [CELL_BITS:0] OCC_D   = (CELL_BITS + 1)'(OCC_DELTA);
  localparam logic signed [CELL_BITS:0] FREE_D  = (CELL_BITS + 1)'(FREE_DELTA);
  localparam logic signed [CELL_BITS:0] MAX_EXT = (CELL_BITS + 1)'((1 << (CELL_BITS - 1)) - 1);
  localparam logic signed [CELL_BITS:0] MIN_EXT = (CELL_BITS + 1)'(-(1 << (CELL_BITS - 1)));

  state_t                 state, next_state;
  logic                   in_range, push, drop, pop, empty;
  logic [ADDR_BITS-1:0]   cell_addr;
  logic [ADDR_BITS:0]     head;
  logic [ADDR_BITS-1:0]   work_addr;
  logic                   work_free;
  logic [CELL_BITS-1:0]   new_val, sat_val;
  logic signed [CELL_BITS:0] old_ext, sum;

  assign in_range  = (32'(x_index) < MAP_WIDTH) && (32'(y_index) < MAP_HEIGHT);
  assign cell_addr = ADDR_BITS'(32'(y_index) * MAP_WIDTH + 32'(x_index));
  // A full queue refuses the write even if the FSM frees a slot on the same edge.
  assign push      = write_enable && in_range && !full;
  assign drop      = write_enable && in_range && full;

  map_fifo #(.WIDTH(ADDR_BITS + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_dat ({cell_addr, cell_is_free}),
    .pop      (pop),
    .pop_dat  (head),
    .full     (full),
    .empty    (empty)
  );

  // One extra bit of headroom so the sum cannot wrap before saturation.
  assign old_ext = {ram_read_data[CELL_BITS-1], ram_read_data};
  assign sum     = work_free ? old_ext - FREE_D : old_ext + OCC_D;
  assign sat_val = (sum > MAX_EXT) ? CELL_BITS'(MAX_EXT) :
                   (sum < MIN_EXT) ? CELL_BITS'(MIN_EXT) : CELL_BITS'(sum);

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          next_state = READ;
        end
      end
      READ:  next_state = WAIT;
      WAIT:  next_state = WRITE;
      WRITE: begin
        if (!empty) begin
          pop        = 1'b1;
          next_state = READ;
        end else begin
          next_state = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      work_addr <= '0;
      work_free <= 1'b0;
      new_val   <= '0;
      overflow  <= 1'b0;
    end else begin
      state <= next_state;
      if (pop) {work_addr, work_free} <= head;
      if (state == WAIT) new_val <= sat_val;
      if (drop) overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

  assign ram_address      = work_addr;
  assign ram_read_enable  = (state == READ);
  assign ram_write_enable = (state == WRITE);
  assign ram_write_data   = new_val;
  assign idle             = empty && (state == IDLE);
endmodule

// File: tb/tb_map_updater.sv
// Bench for map_updater: directed scenarios plus a randomized run against a queue/occupancy reference model.

module tb_map_updater;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  x_index = '0;
  logic [6:0]  y_index = '0;
  logic        cell_is_free = 1'b0;
  logic        write_enable = 1'b0;
  logic        clear_overflow = 1'b0;
  logic [11:0] ram_address;
  logic        ram_read_enable, ram_write_enable;
  logic [7:0]  ram_read_data;
  logic [7:0]  ram_write_data;
  logic        full, idle, overflow;

  int errors = 0;
  int checks = 0;

  logic [7:0]  mem    [4096];
  logic [7:0]  refmap [4096];
  logic [19:0] wlog   [$];
  logic        pk_en = 1'b0;
  logic [11:0] pk_a  = '0;
  logic [7:0]  pk_d  = '0;

  localparam logic [25:0] RST_EXP = {1'b0, 1'b0, 12'd0, 8'd0, 1'b0, 1'b1, 1'b0};

  map_updater dut (
    .clock           (clock),
    .reset           (reset),
    .x_index         (x_index),
    .y_index         (y_index),
    .cell_is_free    (cell_is_free),
    .write_enable    (write_enable),
    .clear_overflow  (clear_overflow),
    .ram_address     (ram_address),
    .ram_read_enable (ram_read_enable),
    .ram_read_data   (ram_read_data),
    .ram_write_enable(ram_write_enable),
    .ram_write_data  (ram_write_data),
    .full            (full),
    .idle            (idle),
    .overflow        (overflow)
  );

  always #5 clock = ~clock;

  // Map RAM with one-cycle read latency; every write is logged in order.
  always @(posedge clock) begin
    if (ram_read_enable) ram_read_data <= mem[ram_address];
    if (ram_write_enable) begin
      mem[ram_address] <= ram_write_data;
      wlog.push_back({ram_address, ram_write_data});
    end
    if (pk_en) mem[pk_a] <= pk_d;
  end

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    pk_en = 1'b1; pk_a = a; pk_d = d;
    cyc();
    pk_en = 1'b0;
  endtask

  task automatic drive(input bit we, input int x, input int y, input bit fr);
    write_enable = we;
    x_index      = 7'(x);
    y_index      = 7'(y);
    cell_is_free = fr;
  endtask

  function automatic logic [7:0] upd(input logic [7:0] old, input bit fr);
    int v;
    v = int'($signed(old)) + (fr ? -1 : 3);
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return 8'(v);
  endfunction

  task automatic test_reset();
    logic [25:0] obs;
    reset = 1'b0;
    drive(0, 0, 0, 0);
    cyc(); cyc();
    obs = {ram_read_enable, ram_write_enable, ram_address, ram_write_data, full, idle, overflow};
    checks++;
    if (obs !== RST_EXP) begin
      errors++; $display("FAIL reset_outputs: got %h want %h", obs, RST_EXP);
    end
    reset = 1'b1;
    cyc();
    checks++;
    if (idle !== 1'b1 || ram_read_enable !== 1'b0) begin
      errors++; $display("FAIL reset_quiet: idle=%b rd=%b want idle=1 rd=0", idle, ram_read_enable);
    end
  endtask

  task automatic test_single();
    int base;
    base = wlog.size();
    poke(12'd133, 8'd10);
    drive(1, 5, 2, 0);
    cyc();
    drive(0, 0, 0, 0);
    checks++;
    if (idle !== 1'b0 || ram_read_enable !== 1'b0) begin
      errors++; $display("FAIL single_plus1: idle=%b rd=%b want idle=0 rd=0", idle, ram_read_enable);
    end
    cyc();
    checks++;
    if (ram_read_enable !== 1'b1 || ram_address !== 12'd133 || ram_write_enable !== 1'b0) begin
      errors++; $display("FAIL single_read: rd=%b addr=%0d wr=%b want rd=1 addr=133 wr=0",
                         ram_read_enable, ram_address, ram_write_enable);
    end
    cyc();
    checks++;
    if (ram_read_enable !== 1'b0 || ram_write_enable !== 1'b0) begin
      errors++; $display("FAIL single_wait: rd=%b wr=%b want 0 0", ram_read_enable, ram_write_enable);
    end
    cyc();
    checks++;
    if (ram_write_enable !== 1'b1 || ram_address !== 12'd133 || ram_write_data !== 8'd13) begin
      errors++; $display("FAIL single_write: wr=%b addr=%0d data=%0d want wr=1 addr=133 data=13",
                         ram_write_enable, ram_address, ram_write_data);
    end
    cyc();
    checks++;
    if (idle !== 1'b1 || wlog.size() !== base + 1) begin
      errors++; $display("FAIL single_done: idle=%b writes=%0d want idle=1 writes=1", idle, wlog.size() - base);
    end
  endtask

  task automatic test_saturation();
    int base;
    base = wlog.size();
    poke(12'd10, 8'd126);
    poke(12'd20, 8'h80);
    drive(1, 10, 0, 0);
    cyc();
    drive(1, 20, 0, 1);
    cyc();
    drive(0, 0, 0, 0);
    for (int i = 0; i < 50 && idle !== 1'b1; i++) cyc();
    checks++;
    if (idle !== 1'b1) begin
      errors++; $display("FAIL sat_drain: idle=%b want 1", idle);
    end
    checks++;
    if (wlog.size() != base + 2) begin
      errors++; $display("FAIL sat_count: writes=%0d want 2", wlog.size() - base);
    end else begin
      checks++;
      if (wlog[base] !== {12'd10, 8'd127}) begin
        errors++; $display("FAIL sat_high: got %h want %h", wlog[base], {12'd10, 8'd127});
      end
      checks++;
      if (wlog[base+1] !== {12'd20, 8'h80}) begin
        errors++; $display("FAIL sat_low: got %h want %h", wlog[base+1], {12'd20, 8'h80});
      end
    end
  endtask

  task automatic test_same_cell();
    int base;
    base = wlog.size();
    poke(12'd0, 8'd0);
    drive(1, 0, 0, 1);
    cyc();
    cyc();
    drive(0, 0, 0, 0);
    for (int i = 0; i < 50 && idle !== 1'b1; i++) cyc();
    checks++;
    if (wlog.size() != base + 2) begin
      errors++; $display("FAIL same_count: writes=%0d want 2", wlog.size() - base);
    end else begin
      checks++;
      if (wlog[base] !== {12'd0, 8'hFF} || wlog[base+1] !== {12'd0, 8'hFE}) begin
        errors++; $display("FAIL same_accum: got %h %h want 000ff 000fe", wlog[base], wlog[base+1]);
      end
    end
  endtask

  task automatic test_out_of_range();
    int xs [3] = '{64, 0, 127};
    int ys [3] = '{0, 64, 127};
    for (int i = 0; i < 3; i++) begin
      drive(1, xs[i], ys[i], 0);
      cyc();
      drive(0, 0, 0, 0);
      checks++;
      if (idle !== 1'b1 || overflow !== 1'b0) begin
        errors++; $display("FAIL oor_%0d: idle=%b ovf=%b want idle=1 ovf=0", i, idle, overflow);
      end
      cyc();
      checks++;
      if (ram_read_enable !== 1'b0) begin
        errors++; $display("FAIL oor_read_%0d: rd=%b want 0", i, ram_read_enable);
      end
    end
  endtask

  // Eight back-to-back free writes: pops land on the 2nd and 5th edges, so the 7th and 8th find the queue full.
  task automatic test_burst();
    int base;
    for (int i = 0; i < 8; i++) poke(12'(192 + i), 8'd0);
    base = wlog.size();
    for (int i = 0; i < 8; i++) begin
      if (i == 5) begin
        checks++;
        if (full !== 1'b0) begin
          errors++; $display("FAIL burst_not_full: full=%b want 0", full);
        end
      end
      if (i == 6) begin
        checks++;
        if (full !== 1'b1) begin
          errors++; $display("FAIL burst_full: full=%b want 1", full);
        end
      end
      drive(1, i, 3, 1);
      cyc();
    end
    drive(0, 0, 0, 0);
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL burst_overflow: ovf=%b want 1", overflow);
    end
    for (int i = 0; i < 60 && idle !== 1'b1; i++) cyc();
    checks++;
    if (wlog.size() != base + 6) begin
      errors++; $display("FAIL burst_count: writes=%0d want 6", wlog.size() - base);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (wlog[base+i] !== {12'(192 + i), 8'hFF}) begin
          errors++; $display("FAIL burst_write_%0d: got %h want %h", i, wlog[base+i], {12'(192 + i), 8'hFF});
        end
      end
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL burst_sticky: ovf=%b want 1", overflow);
    end
    clear_overflow = 1'b1;
    cyc();
    clear_overflow = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL burst_clear: ovf=%b want 0", overflow);
    end
  endtask

  task automatic test_reset_in_wait();
    int  base;
    bit  seen_wr;
    logic [25:0] obs;
    base = wlog.size();
    drive(1, 1, 1, 0);
    cyc();
    drive(0, 0, 0, 0);
    cyc();
    checks++;
    if (ram_read_enable !== 1'b1) begin
      errors++; $display("FAIL rstwait_read: rd=%b want 1", ram_read_enable);
    end
    cyc();
    reset = 1'b0;
    cyc();
    obs = {ram_read_enable, ram_write_enable, ram_address, ram_write_data, full, idle, overflow};
    checks++;
    if (obs !== RST_EXP) begin
      errors++; $display("FAIL rstwait_outputs: got %h want %h", obs, RST_EXP);
    end
    reset = 1'b1;
    seen_wr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (ram_write_enable !== 1'b0) seen_wr = 1'b1;
      cyc();
    end
    checks++;
    if (seen_wr || wlog.size() != base) begin
      errors++; $display("FAIL rstwait_nowrite: seen=%b writes=%0d want 0 0", seen_wr, wlog.size() - base);
    end
  endtask

  task automatic test_random();
    logic [19:0] expw [$];
    int  base, qn, avail, k, x, y, a;
    bit  we, fr, clr, inr, fullb, movf;
    reset = 1'b0;
    drive(0, 0, 0, 0);
    cyc();
    reset = 1'b1;
    for (int i = 0; i < 4096; i++) refmap[i] = mem[i];
    base = wlog.size();
    qn = 0; avail = 0; k = 0; movf = 1'b0;
    for (int c = 0; c < 400; c++) begin
      checks++;
      if (full !== (qn == 4)) begin
        errors++; $display("FAIL rand_full c%0d: full=%b want %b", c, full, qn == 4);
      end
      checks++;
      if (overflow !== movf) begin
        errors++; $display("FAIL rand_ovf c%0d: ovf=%b want %b", c, overflow, movf);
      end
      checks++;
      if ((ram_read_enable & ram_write_enable) !== 1'b0) begin
        errors++; $display("FAIL rand_excl c%0d: rd=%b wr=%b want never both", c, ram_read_enable, ram_write_enable);
      end
      we  = ($urandom_range(0, 99) < 40);
      x   = ($urandom_range(0, 9) == 0) ? 64 + int'($urandom_range(0, 2)) : int'($urandom_range(0, 3));
      y   = ($urandom_range(0, 19) == 0) ? 64 : int'($urandom_range(0, 1));
      fr  = $urandom_range(0, 1);
      clr = ($urandom_range(0, 15) == 0);
      drive(we, x, y, fr);
      clear_overflow = clr;
      // Engine takes one entry every 3 cycles while work is waiting; queue holds 4.
      inr   = (x < 64) && (y < 64);
      fullb = (qn == 4);
      if (qn > 0 && k >= avail) begin
        qn--; avail = k + 3;
      end
      if (we && inr && !fullb) begin
        qn++;
        a = y * 64 + x;
        refmap[a] = upd(refmap[a], fr);
        expw.push_back({12'(a), refmap[a]});
      end
      if (we && inr && fullb) movf = 1'b1;
      else if (clr) movf = 1'b0;
      k++;
      cyc();
    end
    drive(0, 0, 0, 0);
    clear_overflow = 1'b0;
    for (int i = 0; i < 300 && idle !== 1'b1; i++) cyc();
    checks++;
    if (idle !== 1'b1) begin
      errors++; $display("FAIL rand_drain: idle=%b want 1", idle);
    end
    checks++;
    if (wlog.size() - base != expw.size()) begin
      errors++; $display("FAIL rand_count: writes=%0d want %0d", wlog.size() - base, expw.size());
    end
    for (int i = 0; i < expw.size() && base + i < wlog.size(); i++) begin
      checks++;
      if (wlog[base+i] !== expw[i]) begin
        errors++; $display("FAIL rand_write_%0d: got %h want %h", i, wlog[base+i], expw[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_saturation();
    test_same_cell();
    test_out_of_range();
    test_burst();
    test_reset_in_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "time limit");
  end
endmodule
